// File: rtl/blink_pkg.sv
// Shared blink definitions: FSM state encoding and loopback defaults.
// Used by both the blink receiver and the blinker transmitter.
package blink_pkg;

  localparam int BLINK_CNT_W  = 16;
  localparam int BLINK_TOL    = 2;
  localparam int BLINK_LOCK_N = 4;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOST
  } state_e;

endpackage

// File: rtl/blink_sync_edge.sv
// Synchronizes the raw blink input and declares an edge on any level change.
// The BLINK_RX_GLITCH_FILTER_EN macro requires 3 agreeing samples before the level may change.
module blink_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic blink_i,
  output logic level_o,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   level;
  logic                   level_q;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], blink_i};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef BLINK_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[0], synced};
    end
  end

  // The current sample plus two history samples must agree; shorter pulses leave level alone.
  assign level = ((synced == hist_q[0]) && (synced == hist_q[1])) ? synced : level_q;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  assign level_o = level;
  assign edge_o  = (level != level_q);

endmodule

// File: rtl/blink_rx.sv
// Blink receiver: measures each half-period of the synchronized blink input,
// compares it to an expected value within TOL, and tracks lock and timeout.
// The optional glitch filter inside blink_sync_edge is enabled by BLINK_RX_GLITCH_FILTER_EN.
module blink_rx
  import blink_pkg::*;
#(
  parameter int CNT_W       = BLINK_CNT_W,
  parameter int SYNC_STAGES = 2,
  parameter int TOL         = BLINK_TOL,
  parameter int LOCK_N      = BLINK_LOCK_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  input  logic [CNT_W-1:0] expected,
  output logic [CNT_W-1:0] half_period,
  output logic             valid,
  output logic             match,
  output logic             locked,
  output logic             timeout,
  output logic             level
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   TOL_W    = (CNT_W+1)'(TOL);
  localparam logic [3:0]       LOCK_MAX = 4'(LOCK_N);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_period_q, half_period_d;
  logic             valid_q, valid_d;
  logic             match_q, match_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;

  logic             edge_det;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   exp_ext;
  logic [CNT_W:0]   diff;
  logic             in_tol;

  blink_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .blink_i(blink_in),
    .level_o(level),
    .edge_o (edge_det)
  );

  // One extra bit keeps the absolute difference free of wrap-around.
  assign cnt_ext = {1'b0, cnt_q};
  assign exp_ext = {1'b0, expected};
  assign diff    = (cnt_ext >= exp_ext) ? (cnt_ext - exp_ext) : (exp_ext - cnt_ext);
  assign in_tol  = (diff <= TOL_W);

  // NOTE: every output of this block is given a default first, so no latch can be inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    half_period_d = half_period_q;
    valid_d       = 1'b0;
    match_d       = match_q;
    locked_d      = locked_q;
    timeout_d     = timeout_q;
    lock_cnt_d    = lock_cnt_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (edge_det) begin
          state_d = MEASURE;
          cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      MEASURE: begin
        if (edge_det) begin
          half_period_d = cnt_q;
          valid_d       = 1'b1;
          match_d       = in_tol;
          cnt_d         = {{(CNT_W-1){1'b0}}, 1'b1};
          if (in_tol) begin
            lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? LOCK_MAX : lock_cnt_q + 4'd1;
            locked_d   = (lock_cnt_d == LOCK_MAX);
          end else begin
            lock_cnt_d = '0;
            locked_d   = 1'b0;
          end
        end else if (cnt_q == CNT_MAX) begin
          state_d    = LOST;
          timeout_d  = 1'b1;
          locked_d   = 1'b0;
          lock_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LOST: begin
        // The interval that ended here is unbounded, so it is discarded rather than reported.
        if (edge_det) begin
          state_d   = MEASURE;
          cnt_d     = {{(CNT_W-1){1'b0}}, 1'b1};
          timeout_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      half_period_q <= '0;
      valid_q       <= 1'b0;
      match_q       <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_period_q <= half_period_d;
      valid_q       <= valid_d;
      match_q       <= match_d;
      locked_q      <= locked_d;
      timeout_q     <= timeout_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  assign half_period = half_period_q;
  assign valid       = valid_q;
  assign match       = match_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_blink_rx.sv
// Scoreboard bench for blink_rx: stimulus pushes hand-computed measurements,
// a negedge monitor pops and compares on every valid pulse.
module tb_blink_rx;

  logic        clk;
  logic        rst;
  logic        blink_in;
  logic [15:0] expected;
  logic [15:0] half_period;
  logic        valid;
  logic        match;
  logic        locked;
  logic        timeout;
  logic        level;

  typedef struct {
    logic [15:0] hp;
    logic        m;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  blink_rx dut (
    .clk        (clk),
    .rst        (rst),
    .blink_in   (blink_in),
    .expected   (expected),
    .half_period(half_period),
    .valid      (valid),
    .match      (match),
    .locked     (locked),
    .timeout    (timeout),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got half_period %0d with no measurement pending", half_period);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("half_period", {16'd0, half_period}, {16'd0, e.hp});
        check("match", {31'd0, match}, {31'd0, e.m});
        check("locked", {31'd0, locked}, {31'd0, e.l});
      end
    end
  end

  // Toggle blink_in, hold n cycles; optionally expect the interval just started to be reported.
  task automatic seg(input int n, input bit push, input bit m, input bit l);
    exp_t e;
    if (push) begin
      e.hp = 16'(n);
      e.m  = m;
      e.l  = l;
      sb.push_back(e);
    end
    blink_in = ~blink_in;
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [15:0] hp, input bit m, input bit l);
    exp_t e;
    e.hp = hp;
    e.m  = m;
    e.l  = l;
    sb.push_back(e);
  endtask

  task automatic reset_phase();
    check("pending_at_phase_end", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    rst      = 1'b1;
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    blink_in = 1'b0;
    expected = 16'd100;
    repeat (3) @(negedge clk);
    check("rst_half_period", {16'd0, half_period}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_match", {31'd0, match}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_level", {31'd0, level}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean 100-cycle square wave: lock on the 4th valid.
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 1);
    seg(100, 1, 1, 1);
    seg(5, 0, 0, 0);

    // 103 is outside TOL; 98 is exactly at the tolerance edge.
    reset_phase();
    seg(103, 1, 0, 0);
    seg(103, 1, 0, 0);
    seg(103, 1, 0, 0);
    seg(98, 1, 1, 0);
    seg(98, 1, 1, 0);
    seg(98, 1, 1, 0);
    seg(98, 1, 1, 1);
    seg(5, 0, 0, 0);

    // Single bad interval drops lock in the same cycle; relock after 4 good ones.
    reset_phase();
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 1);
    seg(110, 1, 0, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 1);
    seg(5, 0, 0, 0);

    // Lost signal: lock first, then hold the level past counter saturation.
    reset_phase();
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 0);
    seg(100, 1, 1, 1);
    blink_in = ~blink_in;
    repeat (65000) @(negedge clk);
    check("timeout_not_yet", {31'd0, timeout}, 32'd0);
    check("still_locked", {31'd0, locked}, 32'd1);
    repeat (1000) @(negedge clk);
    check("timeout_set", {31'd0, timeout}, 32'd1);
    check("timeout_unlocked", {31'd0, locked}, 32'd0);
    check("timeout_hp_kept", {16'd0, half_period}, 32'd100);
    seg(100, 1, 1, 0);
    check("timeout_cleared", {31'd0, timeout}, 32'd0);
    seg(5, 0, 0, 0);

    // Reset in the middle of a half-period clears outputs at once.
    reset_phase();
    seg(100, 1, 1, 0);
    blink_in = ~blink_in;
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_half_period", {16'd0, half_period}, 32'd0);
    check("midrst_match", {31'd0, match}, 32'd0);
    check("midrst_locked", {31'd0, locked}, 32'd0);
    check("midrst_timeout", {31'd0, timeout}, 32'd0);
    check("midrst_level", {31'd0, level}, 32'd0);
    blink_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    seg(100, 1, 1, 0);
    seg(5, 0, 0, 0);

    // One-cycle glitch inside a 100-cycle half.
    reset_phase();
    seg(100, 1, 1, 0);
`ifdef BLINK_RX_GLITCH_FILTER_EN
    push_exp(16'd100, 1'b1, 1'b0);
`else
    push_exp(16'd40, 1'b0, 1'b0);
    push_exp(16'd1, 1'b0, 1'b0);
    push_exp(16'd59, 1'b0, 1'b0);
`endif
    blink_in = ~blink_in;
    repeat (40) @(negedge clk);
    blink_in = ~blink_in;
    @(negedge clk);
    blink_in = ~blink_in;
    repeat (59) @(negedge clk);
    seg(5, 0, 0, 0);

    repeat (5) @(negedge clk);
    check("pending_at_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
